cpu_bus_cycle: RTL

- Bus-cycle sequencer downstream of the 65C816 address generator.
- Selects the 24-bit CPU bus address from PBR:PC, bank:AA, 00:DX or 00:S.
- Classifies the access speed using the SNES memory map: FAST 6, SLOW 8 or XSLOW 12 master clocks.
- Sequences the read/write strobes and emits the single-cycle EN pulse that advances the core and the address generator.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/cpu_bus_speed.sv | 60 ++++++
 rtl/cpu_bus_cycle.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types for the 65C816 bus-cycle sequencer: access speed classes,
// address-source encodings and the sequencer state enum.
// Optional build macro used by the bus files: CPU_TURBO_EN.
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    SPD_FAST  = 2'd0,
    SPD_SLOW  = 2'd1,
    SPD_XSLOW = 2'd2
  } speed_t;

  localparam logic [1:0] ASEL_PC = 2'd0;  // PBR:PC
  localparam logic [1:0] ASEL_AA = 2'd1;  // (AB+carry):AA
  localparam logic [1:0] ASEL_DX = 2'd2;  // 00:DX
  localparam logic [1:0] ASEL_S  = 2'd3;  // 00:S

  typedef enum logic [1:0] {
    BS_IDLE = 2'd0,
    BS_RUN  = 2'd1,
    BS_HOLD = 2'd2
  } bus_state_t;

endpackage

// File: rtl/cpu_bus_speed.sv
// -----------------------------------------------------------------------------
// cpu_bus_speed
// Purely combinational SNES memory-map speed classifier.
// Ports:
//   addr     in  24  selected CPU bus address (bank:offset)
//   bus_acc  in  1   1 = external access, 0 = internal cycle (always FAST)
//   memsel   in  1   $420D bit 0, FastROM enable
//   turbo    in  1   only with CPU_TURBO_EN: SLOW accesses promoted to FAST
//   speed    out 2   speed class
// Build macro: CPU_TURBO_EN adds the turbo input.
// -----------------------------------------------------------------------------
module cpu_bus_speed
  import cpu_bus_pkg::*;
(
  input  logic [23:0] addr,
  input  logic        bus_acc,
  input  logic        memsel,
`ifdef CPU_TURBO_EN
  input  logic        turbo,
`endif
  output speed_t      speed
);

  logic [7:0]  bank;
  logic [15:0] off;
  speed_t      raw;

  assign bank = addr[23:16];
  assign off  = addr[15:0];

  always_comb begin
    raw = SPD_SLOW;
    if (!bus_acc) begin
      raw = SPD_FAST;
    end else if (bank[6]) begin
      // Banks 40-7F are always SLOW; C0-FF follow FastROM.
      raw = (bank[7] && memsel) ? SPD_FAST : SPD_SLOW;
    end else if (off < 16'h2000) begin
      raw = SPD_SLOW;
    end else if (off < 16'h4000) begin
      raw = SPD_FAST;
    end else if (off < 16'h4200) begin
      raw = SPD_XSLOW;
    end else if (off < 16'h6000) begin
      raw = SPD_FAST;
    end else if (!off[15]) begin
      raw = SPD_SLOW;
    end else begin
      // ROM mirror in the upper half: only the 80-BF copy honours FastROM.
      raw = (bank[7] && memsel) ? SPD_FAST : SPD_SLOW;
    end
  end

`ifdef CPU_TURBO_EN
  assign speed = (turbo && raw == SPD_SLOW) ? SPD_FAST : raw;
`else
  assign speed = raw;
`endif

endmodule

// File: rtl/cpu_bus_cycle.sv
// -----------------------------------------------------------------------------
// cpu_bus_cycle
// Bus-cycle sequencer behind the 65C816 address generator. Selects the 24-bit
// bus address, classifies its speed, drives RD_N/WR_N and emits the one-tick
// EN pulse that steps the core. Parks the CPU on HOLD at cycle boundaries.
// Ports:
//   CLK, RST_N (sync, active-low), CE (master clock enable)
//   ADDR_SEL[1:0], BUS_ACC, WE          cycle request
//   PBR, PC, AA[16:0], AB, DX, S, DO    address/data sources
//   MEMSEL, HOLD                        FastROM enable, DMA stall request
//   TURBO                               only with CPU_TURBO_EN
//   A_OUT[23:0], D_OUT[7:0]             latched address / write data
//   RD_N, WR_N, EN, HOLD_ACK            strobes, core step, hold ack
// Build macro: CPU_TURBO_EN adds the TURBO input.
// -----------------------------------------------------------------------------
module cpu_bus_cycle
  import cpu_bus_pkg::*;
#(
  parameter int FAST_CYC  = 6,
  parameter int SLOW_CYC  = 8,
  parameter int XSLOW_CYC = 12,
  parameter int STB_START = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [1:0]  ADDR_SEL,
  input  logic        BUS_ACC,
  input  logic        WE,
  input  logic [7:0]  PBR,
  input  logic [15:0] PC,
  input  logic [16:0] AA,
  input  logic [7:0]  AB,
  input  logic [15:0] DX,
  input  logic [15:0] S,
  input  logic [7:0]  DO,
  input  logic        MEMSEL,
  input  logic        HOLD,
`ifdef CPU_TURBO_EN
  input  logic        TURBO,
`endif
  output logic [23:0] A_OUT,
  output logic [7:0]  D_OUT,
  output logic        RD_N,
  output logic        WR_N,
  output logic        EN,
  output logic        HOLD_ACK
);

  localparam int CW = $clog2(XSLOW_CYC + 1);

  bus_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_sel;
  logic        we_q, bus_q, rd_n_q, wr_n_q, rd_n_d, wr_n_d;
  logic [23:0] a_q, sel_addr;
  logic [7:0]  d_q, bank_aa;
  logic        start, last, strobe_on;
  speed_t      speed;

  // Address source mux; the AA carry bumps the bank with 8-bit wrap.
  assign bank_aa = AB + {7'd0, AA[16]};

  always_comb begin
    sel_addr = {PBR, PC};
    case (ADDR_SEL)
      ASEL_PC: sel_addr = {PBR, PC};
      ASEL_AA: sel_addr = {bank_aa, AA[15:0]};
      ASEL_DX: sel_addr = {8'h00, DX};
      ASEL_S:  sel_addr = {8'h00, S};
      default: sel_addr = {PBR, PC};
    endcase
  end

  cpu_bus_speed u_speed (
    .addr    (sel_addr),
    .bus_acc (BUS_ACC),
    .memsel  (MEMSEL),
`ifdef CPU_TURBO_EN
    .turbo   (TURBO),
`endif
    .speed   (speed)
  );

  always_comb begin
    case (speed)
      SPD_FAST:  len_sel = CW'(FAST_CYC);
      SPD_SLOW:  len_sel = CW'(SLOW_CYC);
      SPD_XSLOW: len_sel = CW'(XSLOW_CYC);
      default:   len_sel = CW'(SLOW_CYC);
    endcase
  end

  assign last = (cnt_q == len_q - CW'(1));

  // Next-state: every transition happens only on a CE tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    if (CE) begin
      case (state_q)
        BS_IDLE: begin
          start   = 1'b1;
          state_d = BS_RUN;
          cnt_d   = '0;
        end
        BS_RUN: begin
          if (last) begin
            if (HOLD) begin
              state_d = BS_HOLD;
            end else begin
              start = 1'b1;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BS_HOLD: begin
          if (!HOLD) begin
            start   = 1'b1;
            state_d = BS_RUN;
            cnt_d   = '0;
          end
        end
        default: state_d = BS_IDLE;
      endcase
    end

    // Strobes are registered against the count the next tick lands on, so a
    // cycle start (count 0) or a move into HOLD always releases them.
    strobe_on = (state_d == BS_RUN) && !start && bus_q &&
                (cnt_d >= CW'(STB_START));
    rd_n_d = CE ? !(strobe_on && !we_q) : rd_n_q;
    wr_n_d = CE ? !(strobe_on &&  we_q) : wr_n_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= BS_IDLE;
      cnt_q   <= '0;
      len_q   <= CW'(FAST_CYC);
      we_q    <= 1'b0;
      bus_q   <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      if (start) begin
        a_q   <= sel_addr;
        d_q   <= DO;
        len_q <= len_sel;
        we_q  <= WE;
        bus_q <= BUS_ACC;
      end
    end
  end

  assign A_OUT    = a_q;
  assign D_OUT    = d_q;
  assign RD_N     = rd_n_q;
  assign WR_N     = wr_n_q;
  // Gated by CE and reset so a step can never leak outside a live CE tick.
  assign EN       = RST_N && CE && (state_q == BS_RUN) && last;
  assign HOLD_ACK = (state_q == BS_HOLD);

endmodule
